ram_datos_bytes: RTL and testbench
==================================

Name: ram_datos_bytes

Overview:
Parametrised successor to the TP4 MIPS data RAM, serving the MEM stage with byte, halfword and word loads and stores. Loads are sign- or zero-extended, and misaligned accesses are detected. A sequencer clears memory after reset. A debug dump streams the whole memory to the debug unit over a valid/ready handshake.

Parameters:
RAM_WIDTH, 32, word width in bits; must be 32 (byte lanes fixed at 4).
RAM_DEPTH, 1024, number of words; power of two.
ADDR_WIDTH, clogb2(RAM_DEPTH-1)+2, byte-address width (derived; do not override).

Ports:
clka  in  1  clock; all state updates on the falling edge of clka.
rsta_n  in  1  asynchronous active-low reset.
ena  in  1  access enable from MEM stage.
wea  in  1  store when 1, load when 0 (qualified by ena).
size  in  2  access size: 00 byte, 01 halfword, 11 word (10 is treated as word).
unsig  in  1  load zero-extend when 1 (LBU/LHU), sign-extend when 0.
addra  in  ADDR_WIDTH  byte address.
dina  in  32  store data; the byte or halfword is taken from the low bits.
douta  out  32  registered, extended load data.
douta_wire  out  32  combinational raw word at addra[ADDR_WIDTH-1:2].
misalign  out  1  registered; one-cycle pulse for a misaligned access.
busy  out  1  high during CLEAR or DUMP.
dump_req  in  1  one-cycle request to start a dump.
dump_data  out  32  word being dumped.
dump_addr  out  ADDR_WIDTH-2  word index of dump_data.
dump_valid  out  1  dump_data is valid.
dump_ready  in  1  debug unit accepts the word.
dump_done  out  1  one-cycle pulse after the last word is accepted.

Behaviour:
- Reset (async assert, any state): state=CLEAR, clear pointer=0, douta=0, misalign=0, busy=1, dump_valid=0, dump_done=0, dump_addr=0. Memory is not touched by reset itself.
- CLEAR: writes one word per cycle at the pointer, value 0. After word RAM_DEPTH-1 is written, the FSM goes to IDLE and busy drops on the same edge. This takes exactly RAM_DEPTH cycles from reset release.
- IDLE with ena=1:
  - Alignment: halfword requires addr[0]=0; word requires addr[1:0]=00. Byte accesses are always aligned.
  - Misaligned access: no write, douta<=0, misalign=1 for one cycle.
  - Store byte: writes lane addr[1:0] with dina[7:0].
  - Store halfword: writes lanes {addr[1],0} with dina[15:0].
  - Store word: writes the full word. Other lanes are preserved.
  - Store cycle: douta holds its previous value (no-change write mode).
  - Load: douta is updated on the same falling edge the address is sampled. Byte is extended from bit 7 and halfword from bit 15 per unsig; word is passed unchanged.
- IDLE with ena=0: douta holds.
- dump_req in IDLE: go to DUMP, pointer=0, busy=1.
- dump_req is ignored in CLEAR and DUMP.
- CPU ena/wea are ignored while busy=1: no write, douta holds, misalign=0.
- DUMP:
  - dump_valid=1, dump_data=mem[pointer], dump_addr=pointer.
  - On dump_valid && dump_ready, the pointer increments.
  - dump_data and dump_addr stay stable while dump_ready=0.
  - After word RAM_DEPTH-1 is accepted: dump_valid=0, dump_done=1 for one cycle, state=IDLE, busy=0.
- Pointer wrap: the pointer never wraps. Exit is on the last index.
- Reset mid-DUMP or mid-CLEAR aborts the operation and restarts CLEAR. dump_done is not produced.
- douta_wire is always combinational from the array, including during busy.

Optional Feature:
RAM_DATOS_INIT_PATTERN_EN: when defined, CLEAR writes word i with value i+128 (debug test pattern). When undefined, CLEAR writes 0. Timing and all other behaviour are identical in both cases.

Test Plan:
- Reset, release, wait RAM_DEPTH cycles -> busy falls exactly at cycle RAM_DEPTH; load word at addr 0x10 -> douta=0x00000000 (0x00000084 with RAM_DATOS_INIT_PATTERN_EN).
- Store word 0x8899AABB at 0x20, store byte 0x7F at 0x22; then LB 0x20 -> 0xFFFFFFBB, LBU 0x20 -> 0x000000BB, LH 0x22 -> 0xFFFF887F, LW 0x20 -> 0x887FAABB.
- LW at 0x21 -> misalign pulse for 1 cycle, douta=0; SH at 0x23 with dina=0x1234 -> misalign=1 and a later LW 0x20 is unchanged.
- With RAM_DEPTH=16, pulse dump_req and hold dump_ready low for 3 cycles at word 5 -> dump_data/dump_addr stable; 16 words transferred in order; dump_done=1 exactly once; busy=0 afterwards.
- Assert a store with ena=1 while busy (CLEAR or DUMP) -> memory unchanged, douta unchanged.
- Assert rsta_n=0 at dump word 7 -> dump_valid=0 immediately, busy=1, CLEAR restarts; dump_done is never asserted.

Source files
------------

// File: rtl/ram_datos_bytes.sv
// Data RAM for the MIPS MEM stage: byte/halfword/word loads (sign/zero
// extended) and stores. It detects misaligned accesses, clears itself after
// reset and can stream its contents to the debug unit.
// Latency: loads, misalign and FSM state update on the falling edge of clka;
// douta_wire is combinational.
// Backpressure: the dump stream holds dump_data/dump_addr until dump_ready.
// CPU accesses are dropped while busy.
//
// Ports:
//   clka, rsta_n      clock (falling-edge state) and async active-low reset
//   ena, wea, size,   CPU access: enable, store/load, 00 B / 01 H / 1x W,
//   unsig, addra,     zero-extend loads, byte address, store data
//   dina
//   douta             registered extended load data
//   douta_wire        combinational raw word at addra
//   misalign          one-cycle pulse for a misaligned access
//   busy              high while clearing or dumping
//   dump_*            dump request, word/index stream with valid/ready, done pulse
//
// Optional macro RAM_DATOS_INIT_PATTERN_EN: when it is defined, the clear
// sequence writes word i with i+128 instead of zero.

module ram_datos_bytes #(
  parameter int RAM_WIDTH  = 32,
  parameter int RAM_DEPTH  = 1024,
  parameter int ADDR_WIDTH = $clog2(RAM_DEPTH) + 2
) (
  input  logic                  clka,
  input  logic                  rsta_n,
  input  logic                  ena,
  input  logic                  wea,
  input  logic [1:0]            size,
  input  logic                  unsig,
  input  logic [ADDR_WIDTH-1:0] addra,
  input  logic [RAM_WIDTH-1:0]  dina,
  output logic [RAM_WIDTH-1:0]  douta,
  output logic [RAM_WIDTH-1:0]  douta_wire,
  output logic                  misalign,
  output logic                  busy,
  input  logic                  dump_req,
  output logic [RAM_WIDTH-1:0]  dump_data,
  output logic [ADDR_WIDTH-3:0] dump_addr,
  output logic                  dump_valid,
  input  logic                  dump_ready,
  output logic                  dump_done
);

  localparam int PW = ADDR_WIDTH - 2;
  localparam logic [PW-1:0] LAST_IDX = PW'(RAM_DEPTH - 1);

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_DUMP  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [PW-1:0]          ptr_q, ptr_d;
  logic [RAM_WIDTH-1:0]   douta_q, douta_d;
  logic                   misalign_q, misalign_d;
  logic                   done_q, done_d;

  logic [RAM_WIDTH-1:0]   mem_q [RAM_DEPTH];

  logic [PW-1:0]          word_idx;
  logic [RAM_WIDTH-1:0]   rd_word;
  logic [RAM_WIDTH-1:0]   load_val;
  logic [RAM_WIDTH-1:0]   wdat;
  logic [3:0]             be;
  logic [RAM_WIDTH-1:0]   clr_val;
  logic                   misal;
  logic                   clr_we;
  logic                   cpu_we;
  logic [7:0]             rd_byte;
  logic [15:0]            rd_half;

  assign word_idx = addra[ADDR_WIDTH-1:2];
  assign rd_word  = mem_q[word_idx];

  // Halfword needs addr[0]=0. Word (size 1x) needs addr[1:0]=00.
  assign misal = ((size == 2'b01) && addra[0]) ||
                 (size[1] && (addra[1:0] != 2'b00));

`ifdef RAM_DATOS_INIT_PATTERN_EN
  assign clr_val = RAM_WIDTH'(ptr_q) + RAM_WIDTH'(128);
`else
  assign clr_val = '0;
`endif

  // Select the lane(s) being loaded, then extend to the full word.
  always_comb begin
    rd_byte  = '0;
    rd_half  = '0;
    load_val = rd_word;
    case (addra[1:0])
      2'd0:    rd_byte = rd_word[7:0];
      2'd1:    rd_byte = rd_word[15:8];
      2'd2:    rd_byte = rd_word[23:16];
      default: rd_byte = rd_word[31:24];
    endcase
    rd_half = addra[1] ? rd_word[31:16] : rd_word[15:0];
    case (size)
      2'b00:   load_val = {{24{rd_byte[7] & ~unsig}}, rd_byte};
      2'b01:   load_val = {{16{rd_half[15] & ~unsig}}, rd_half};
      default: load_val = rd_word;
    endcase
  end

  // Replicate narrow store data across lanes. The byte enables then pick
  // the lane(s) that are actually written.
  always_comb begin
    wdat = dina;
    be   = 4'b1111;
    case (size)
      2'b00: begin
        wdat = {4{dina[7:0]}};
        be   = 4'b0001 << addra[1:0];
      end
      2'b01: begin
        wdat = {2{dina[15:0]}};
        be   = addra[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        wdat = dina;
        be   = 4'b1111;
      end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    douta_d    = douta_q;
    misalign_d = 1'b0;
    done_d     = 1'b0;
    clr_we     = 1'b0;
    cpu_we     = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        clr_we = 1'b1;
        if (ptr_q == LAST_IDX) begin
          state_d = ST_IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + PW'(1);
        end
      end
      ST_IDLE: begin
        if (ena) begin
          if (misal) begin
            misalign_d = 1'b1;
            douta_d    = '0;
          end else if (wea) begin
            cpu_we = 1'b1;        // no-change mode: douta keeps its value
          end else begin
            douta_d = load_val;
          end
        end
        if (dump_req) begin
          state_d = ST_DUMP;
          ptr_d   = '0;
        end
      end
      ST_DUMP: begin
        if (dump_ready) begin
          if (ptr_q == LAST_IDX) begin
            state_d = ST_IDLE;
            ptr_d   = '0;
            done_d  = 1'b1;
          end else begin
            ptr_d = ptr_q + PW'(1);
          end
        end
      end
      default: begin
        state_d = ST_CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  always_ff @(negedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      state_q    <= ST_CLEAR;
      ptr_q      <= '0;
      douta_q    <= '0;
      misalign_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      douta_q    <= douta_d;
      misalign_q <= misalign_d;
      done_q     <= done_d;
    end
  end

  // The array itself is never reset. The clear sequence initialises it.
  always_ff @(negedge clka) begin
    if (clr_we) begin
      mem_q[ptr_q] <= clr_val;
    end else if (cpu_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem_q[word_idx][8*i +: 8] <= wdat[8*i +: 8];
        end
      end
    end
  end

  assign douta      = douta_q;
  assign douta_wire = rd_word;
  assign misalign   = misalign_q;
  assign busy       = (state_q != ST_IDLE);
  assign dump_valid = (state_q == ST_DUMP);
  assign dump_data  = mem_q[ptr_q];
  assign dump_addr  = (state_q == ST_DUMP) ? ptr_q : '0;
  assign dump_done  = done_q;

endmodule

// File: tb/tb_ram_datos_bytes.sv
module tb_ram_datos_bytes;

  localparam int DEPTH = 16;
  localparam int AW    = 6;

  logic          clka = 1'b1;
  logic          rsta_n, ena, wea, unsig, dump_req, dump_ready;
  logic [1:0]    size;
  logic [AW-1:0] addra;
  logic [31:0]   dina, douta, douta_wire, dump_data;
  logic          misalign, busy, dump_valid, dump_done;
  logic [AW-3:0] dump_addr;

  int checks   = 0;
  int failures = 0;
  logic [31:0] model [DEPTH];

  ram_datos_bytes #(.RAM_WIDTH(32), .RAM_DEPTH(DEPTH)) dut (
    .clka       (clka),
    .rsta_n     (rsta_n),
    .ena        (ena),
    .wea        (wea),
    .size       (size),
    .unsig      (unsig),
    .addra      (addra),
    .dina       (dina),
    .douta      (douta),
    .douta_wire (douta_wire),
    .misalign   (misalign),
    .busy       (busy),
    .dump_req   (dump_req),
    .dump_data  (dump_data),
    .dump_addr  (dump_addr),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_done  (dump_done)
  );

  always #5 clka = ~clka;

  function automatic logic [31:0] clrval(input int i);
`ifdef RAM_DATOS_INIT_PATTERN_EN
    return 32'(i + 128);
`else
    return 32'(i - i);
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // DUT acts on negedge. Stimulus changes and sampling happen at posedge.
  task automatic cyc();
    @(negedge clka);
    @(posedge clka);
  endtask

  task automatic acc(input logic we, input logic [1:0] sz, input logic us,
                     input logic [AW-1:0] a, input logic [31:0] d);
    ena = 1'b1; wea = we; size = sz; unsig = us; addra = a; dina = d;
    cyc();
    ena = 1'b0; wea = 1'b0;
  endtask

  initial begin
    int idx, stall, done_cnt;
    bit found;
    rsta_n = 1'b0; ena = 0; wea = 0; unsig = 0; dump_req = 0; dump_ready = 0;
    size = 2'b00; addra = '0; dina = '0;
    repeat (2) @(posedge clka);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_douta", douta, 32'h0);
    chk("rst_misal", 32'(misalign), 32'd0);
    chk("rst_dvalid", 32'(dump_valid), 32'd0);
    chk("rst_ddone", 32'(dump_done), 32'd0);
    chk("rst_daddr", 32'(dump_addr), 32'd0);

    // Release, with a misaligned store attempted during CLEAR.
    rsta_n = 1'b1;
    ena = 1; wea = 1; size = 2'b11; addra = 6'h21; dina = 32'hDEADBEEF;
    cyc();
    ena = 0; wea = 0;
    chk("clr_misal", 32'(misalign), 32'd0);
    chk("clr_douta", douta, 32'h0);
    repeat (DEPTH - 2) cyc();
    chk("clr_busy_n-1", 32'(busy), 32'd1);
    cyc();
    chk("clr_busy_n", 32'(busy), 32'd0);
    for (int i = 0; i < DEPTH; i++) model[i] = clrval(i);

    acc(0, 2'b11, 0, 6'h10, 32'h0);
    chk("lw_10", douta, clrval(4));
    acc(1, 2'b11, 0, 6'h20, 32'h8899AABB);
    chk("sw_hold", douta, clrval(4));
    acc(1, 2'b00, 0, 6'h22, 32'hFFFFFF7F);
    model[8] = 32'h887FAABB;
    acc(0, 2'b00, 0, 6'h20, 32'h0); chk("lb_20", douta, 32'hFFFFFFBB);
    acc(0, 2'b00, 1, 6'h20, 32'h0); chk("lbu_20", douta, 32'h000000BB);
    acc(0, 2'b01, 0, 6'h22, 32'h0); chk("lh_22", douta, 32'hFFFF887F);
    acc(0, 2'b01, 1, 6'h22, 32'h0); chk("lhu_22", douta, 32'h0000887F);
    acc(0, 2'b00, 0, 6'h22, 32'h0); chk("lb_22", douta, 32'h0000007F);
    acc(0, 2'b11, 0, 6'h20, 32'h0); chk("lw_20", douta, 32'h887FAABB);

    acc(0, 2'b11, 0, 6'h21, 32'h0);
    chk("lw21_misal", 32'(misalign), 32'd1);
    chk("lw21_douta", douta, 32'h0);
    cyc();
    chk("misal_pulse", 32'(misalign), 32'd0);
    acc(1, 2'b01, 0, 6'h23, 32'h00001234);
    chk("sh23_misal", 32'(misalign), 32'd1);
    acc(0, 2'b11, 0, 6'h20, 32'h0);
    chk("sh23_nowr", douta, 32'h887FAABB);
    chk("lw20_nomisal", 32'(misalign), 32'd0);
    acc(1, 2'b01, 0, 6'h20, 32'hCAFE5678);
    model[8] = 32'h887F5678;
    acc(0, 2'b01, 0, 6'h20, 32'h0);
    chk("lh_20", douta, 32'h00005678);
    chk("douta_wire", douta_wire, 32'h887F5678);

    // Dump with a stall at word 5 and a blocked store plus a stray dump_req.
    dump_req = 1; dump_ready = 1;
    cyc();
    dump_req = 0;
    chk("dump_busy", 32'(busy), 32'd1);
    idx = 0; stall = 0; done_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (dump_done) done_cnt++;
      if (c == 2) begin
        ena = 1; wea = 1; size = 2'b11; addra = 6'h20; dina = 32'h0;
      end else begin
        ena = 0; wea = 0;
      end
      dump_req = (c == 10);
      if (dump_valid) begin
        if (idx == 5 && stall < 3) begin
          dump_ready = 0;
          chk("stall_dat", dump_data, model[5]);
          chk("stall_addr", 32'(dump_addr), 32'd5);
          stall++;
        end else begin
          dump_ready = 1;
          if (idx < DEPTH) begin
            chk("dump_dat", dump_data, model[idx]);
            chk("dump_addr", 32'(dump_addr), 32'(idx));
          end
          idx++;
        end
      end
      cyc();
    end
    dump_req = 0;
    chk("dump_words", 32'(idx), 32'(DEPTH));
    chk("dump_done_cnt", 32'(done_cnt), 32'd1);
    chk("dump_busy_end", 32'(busy), 32'd0);
    chk("dump_valid_end", 32'(dump_valid), 32'd0);
    chk("dump_douta_hold", douta, 32'h00005678);
    acc(0, 2'b11, 0, 6'h20, 32'h0);
    chk("lw20_after_dump", douta, 32'h887F5678);

    // Reset in the middle of a dump.
    dump_ready = 1; dump_req = 1;
    cyc();
    dump_req = 0;
    found = 0;
    for (int c = 0; c < 40; c++) begin
      if (dump_valid && dump_addr == 4'd7) begin
        found = 1;
        break;
      end
      cyc();
    end
    chk("abort_reach7", 32'(found), 32'd1);
    rsta_n = 0;
    #1;
    chk("abort_valid", 32'(dump_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd1);
    chk("abort_daddr", 32'(dump_addr), 32'd0);
    @(posedge clka);
    rsta_n = 1;
    done_cnt = 0;
    for (int n = 1; n <= DEPTH; n++) begin
      cyc();
      if (dump_done) done_cnt++;
      if (n == DEPTH - 1) chk("reclr_busy", 32'(busy), 32'd1);
    end
    chk("reclr_idle", 32'(busy), 32'd0);
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    acc(0, 2'b11, 0, 6'h20, 32'h0);
    chk("lw20_recleared", douta, clrval(8));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
